msrv32_target_addr_unit: RTL and testbench
==========================================

Name: msrv32_target_addr_unit

Overview:
- Parametrised, pipelined successor to the single-cycle immediate adder in the msrv32 core.
- Computes branch, jump, JALR and load/store effective addresses, plus the sequential PC, in one shared adder.
- Adds a valid/ready handshake, a pipeline-flush input, JALR LSB clearing and instruction-address-misaligned detection.
- Sits between decode/register-read and the PC-mux/LSU stages.

Parameters:
- XLEN, 32: datapath width of the pc, rs1, imm and result signals.
- PIPE_STAGES, 1: number of register stages between operand capture and result. Legal range 1..3.
- ALIGN_BITS, 2: low target bits that must be zero for a legal fetch target. Set to 1 when the C extension is enabled.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
- flush_in  input  1  discard all in-flight operations
- valid_in  input  1  operands valid
- ready_out  output  1  unit can accept operands this cycle
- mode_in  input  2  00 pc+imm, 01 rs1+imm, 10 (rs1+imm) with bit0 cleared (JALR), 11 pc+4
- pc_in  input  XLEN  program counter
- rs1_in  input  XLEN  register source 1
- imm_in  input  XLEN  sign-extended immediate
- valid_out  output  1  result valid
- ready_in  input  1  downstream accepts result
- iadder_out  output  XLEN  computed address
- misaligned_out  output  1  target violates ALIGN_BITS alignment (modes 00 and 10 only)
- mode_out  output  2  mode of the result currently presented

Behaviour:
- Clock and reset: one clock, ms_riscv32_mp_clk_in. Reset ms_riscv32_mp_rst_in is asynchronous and active-high.
- Reset values: all stage valids, valid_out, iadder_out, misaligned_out and mode_out are 0. ready_out is 1 once reset deasserts.
- Arithmetic: sum is taken modulo 2^XLEN; carry-out is discarded and no overflow is flagged.
  - Mode 10 forces result bit0 to 0 after the add.
  - Mode 11 ignores imm_in and rs1_in.
- Alignment: misaligned_out = OR of result[ALIGN_BITS-1:0], evaluated after the bit0 clear. It is forced to 0 for modes 01 and 11.
- Computation stage: add and alignment check happen combinationally on capture. The result registers into stage 1. Stages 2..PIPE_STAGES are plain register stages.
- Latency: an accepted operation appears on valid_out exactly PIPE_STAGES cycles after capture, provided there is no backpressure.
- Handshake:
  - Input transfer occurs when valid_in && ready_out.
  - Output transfer occurs when valid_out && ready_in.
  - Outputs are driven directly from the last stage register.
- Stage advance: stage k advances when it is empty or stage k+1 advances. The last stage advances when ready_in=1.
  - Bubbles collapse, so the pipeline holds up to PIPE_STAGES operations.
  - ready_out = stage1 empty OR stage1 advancing.
- Stall: while valid_out=1 and ready_in=0, iadder_out, misaligned_out and mode_out hold stable. No in-flight result is overwritten or dropped.
- Flush:
  - flush_in=1 clears every stage valid at the next edge.
  - Any input offered that cycle is not captured, even if valid_in && ready_out.
  - ready_out remains 1 during flush.
  - Flush has priority over simultaneous input capture and over output transfer. The downstream must not count a result presented during the flush cycle as transferred.
- Data registers: registers of invalid stages may hold stale data. valid_out gates their meaning.
- Simultaneous transfer: when the unit is full and output and input transfer in the same cycle, throughput is 1 per cycle with no bubble.
- Reset mid-operation: asynchronous clear of all stages; in-flight operations are lost with no partial output.
- Illegal parameter: PIPE_STAGES outside 1..3 is an elaboration error.

Test Plan:
- Mode 00, PIPE_STAGES=1, pc=0x0000_1000, imm=0xFFFF_FFFC -> one cycle later valid_out=1, iadder_out=0x0000_0FFC, misaligned_out=0.
- Mode 10, rs1=0x0000_2003, imm=0 -> iadder_out=0x0000_2002. With ALIGN_BITS=2, misaligned_out=1; with ALIGN_BITS=1, misaligned_out=0.
- Mode 01, rs1=0xFFFF_FFFF, imm=2 -> iadder_out=0x0000_0001 (wrap), misaligned_out=0. Mode 11, pc=0x0000_0100 -> 0x0000_0104.
- PIPE_STAGES=3, back-to-back valid_in for 6 cycles, ready_in=0 from cycle 4 to cycle 8:
  - ready_out drops once the 3 stages are full.
  - Outputs hold stable.
  - All 6 results emerge in order with no loss or duplicate.
- Flush asserted with 2 operations in flight and valid_in=1 -> next cycle valid_out=0. The flushed-cycle input never appears. The next accepted operation has latency PIPE_STAGES.
- Assert ms_riscv32_mp_rst_in asynchronously mid-stall -> valid_out, iadder_out, misaligned_out and mode_out are 0 immediately without a clock edge. ready_out=1 after release.

Source files
------------

// File: rtl/msrv32_target_addr_unit.sv
// Shared target/effective-address adder for branch, jump, JALR, load/store and pc+4.
// Latency PIPE_STAGES cycles; bubbles collapse and ready_out follows stage-1 advance.
`timescale 1ns/1ps
module msrv32_target_addr_unit #(
   parameter int XLEN        = 32,
   parameter int PIPE_STAGES = 1,
   parameter int ALIGN_BITS  = 2
) (
   input  logic            ms_riscv32_mp_clk_in,
   input  logic            ms_riscv32_mp_rst_in,
   input  logic            flush_in,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic [1:0]      mode_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs1_in,
   input  logic [XLEN-1:0] imm_in,
   output logic            valid_out,
   input  logic            ready_in,
   output logic [XLEN-1:0] iadder_out,
   output logic            misaligned_out,
   output logic [1:0]      mode_out
);

   localparam int LAST = PIPE_STAGES - 1;

   if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
      $error("msrv32_target_addr_unit: PIPE_STAGES must be in 1..3");
   end

   logic [PIPE_STAGES-1:0] stg_vld;
   logic [PIPE_STAGES-1:0] stg_mis;
   logic [PIPE_STAGES-1:0] adv;
   logic [XLEN-1:0]        stg_addr [PIPE_STAGES];
   logic [1:0]             stg_mode [PIPE_STAGES];

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] addr;
   logic            mis;
   logic            chain;

   // Modes 00 and 11 take pc as the base; the others take rs1.
   always_comb begin
      op_a = (mode_in[0] == mode_in[1]) ? pc_in : rs1_in;
      op_b = (mode_in == 2'b11) ? XLEN'(4) : imm_in;
      sum  = op_a + op_b;
      addr = sum;
      if (mode_in == 2'b10) begin
         addr[0] = 1'b0;
      end
      mis = ~mode_in[0] & (|addr[ALIGN_BITS-1:0]);
   end

   always_comb begin
      chain = ready_in;
      adv   = '0;
      for (int k = LAST; k >= 0; k--) begin
         chain  = chain | ~stg_vld[k];
         adv[k] = chain;
      end
   end

   assign ready_out = adv[0] | flush_in;

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         stg_vld <= '0;
         stg_mis <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            stg_addr[k] <= '0;
            stg_mode[k] <= '0;
         end
      end else begin
         if (adv[0]) begin
            stg_vld[0] <= valid_in & ~flush_in;
            if (valid_in) begin
               stg_addr[0] <= addr;
               stg_mis[0]  <= mis;
               stg_mode[0] <= mode_in;
            end
         end
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (adv[k]) begin
               stg_vld[k]  <= stg_vld[k-1];
               stg_addr[k] <= stg_addr[k-1];
               stg_mis[k]  <= stg_mis[k-1];
               stg_mode[k] <= stg_mode[k-1];
            end
         end
         // Flush wins over both capture and output transfer.
         if (flush_in) begin
            stg_vld <= '0;
         end
      end
   end

   assign valid_out      = stg_vld[LAST];
   assign iadder_out     = stg_addr[LAST];
   assign misaligned_out = stg_mis[LAST];
   assign mode_out       = stg_mode[LAST];

endmodule

// File: tb/tb_msrv32_target_addr_unit.sv
// Bench for msrv32_target_addr_unit: a 3-stage/ALIGN=2 and a 1-stage/ALIGN=1 instance share stimulus.
`timescale 1ns/1ps
module tb_msrv32_target_addr_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_in = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_in = 1'b1;
   logic [1:0]  mode_in = 2'b00;
   logic [31:0] pc_in = '0;
   logic [31:0] rs1_in = '0;
   logic [31:0] imm_in = '0;

   logic        ro_a, vo_a, mis_a;
   logic [31:0] io_a;
   logic [1:0]  mo_a;
   logic        ro_b, vo_b, mis_b;
   logic [31:0] io_b;
   logic [1:0]  mo_b;

   int total = 0;
   int bad = 0;

   msrv32_target_addr_unit #(.XLEN(32), .PIPE_STAGES(3), .ALIGN_BITS(2)) dut_a (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush_in),
      .valid_in(valid_in), .ready_out(ro_a), .mode_in(mode_in), .pc_in(pc_in),
      .rs1_in(rs1_in), .imm_in(imm_in), .valid_out(vo_a), .ready_in(ready_in),
      .iadder_out(io_a), .misaligned_out(mis_a), .mode_out(mo_a));

   msrv32_target_addr_unit #(.XLEN(32), .PIPE_STAGES(1), .ALIGN_BITS(1)) dut_b (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .flush_in(flush_in),
      .valid_in(valid_in), .ready_out(ro_b), .mode_in(mode_in), .pc_in(pc_in),
      .rs1_in(rs1_in), .imm_in(imm_in), .valid_out(vo_b), .ready_in(ready_in),
      .iadder_out(io_b), .misaligned_out(mis_b), .mode_out(mo_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: {mode, misaligned, address}
   function automatic logic [34:0] model(input logic [1:0] m, input logic [31:0] p,
                                         input logic [31:0] r, input logic [31:0] i,
                                         input int align);
      logic [31:0] s;
      logic        ms;
      case (m)
         2'b00:   s = p + i;
         2'b01:   s = r + i;
         2'b10:   s = (r + i) & 32'hFFFF_FFFE;
         default: s = p + 32'd4;
      endcase
      ms = (m == 2'b00 || m == 2'b10) && ((s & ((32'd1 << align) - 32'd1)) != 32'd0);
      return {m, ms, s};
   endfunction

   logic [34:0] qa[$];
   logic [34:0] qb[$];
   logic [34:0] ea, eb;
   int na = 0;
   int nb = 0;

   always @(negedge clk) begin
      if (rst || flush_in) begin
         qa.delete();
         qb.delete();
      end else begin
         if (vo_a) begin
            if (qa.size() == 0) begin
               chk("a_spurious_out", 64'(vo_a), 64'd0);
            end else begin
               ea = qa[0];
               chk("a_addr", 64'(io_a), 64'(ea[31:0]));
               chk("a_mis", 64'(mis_a), 64'(ea[32]));
               chk("a_mode", 64'(mo_a), 64'(ea[34:33]));
               if (ready_in) begin
                  void'(qa.pop_front());
                  na++;
               end
            end
         end
         if (vo_b) begin
            if (qb.size() == 0) begin
               chk("b_spurious_out", 64'(vo_b), 64'd0);
            end else begin
               eb = qb[0];
               chk("b_addr", 64'(io_b), 64'(eb[31:0]));
               chk("b_mis", 64'(mis_b), 64'(eb[32]));
               chk("b_mode", 64'(mo_b), 64'(eb[34:33]));
               if (ready_in) begin
                  void'(qb.pop_front());
                  nb++;
               end
            end
         end
         if (valid_in && ro_a) qa.push_back(model(mode_in, pc_in, rs1_in, imm_in, 2));
         if (valid_in && ro_b) qb.push_back(model(mode_in, pc_in, rs1_in, imm_in, 1));
      end
   end

   // Called at posedge+1; holds valid_in until dut_a accepts, returns at posedge+1 after capture.
   task automatic send(input logic [1:0] m, input logic [31:0] p, input logic [31:0] r,
                       input logic [31:0] i);
      int n;
      mode_in = m; pc_in = p; rs1_in = r; imm_in = i;
      valid_in = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ro_a && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!ro_a) chk("send_timeout", 64'(ro_a), 64'd1);
      @(posedge clk);
      #1 valid_in = 1'b0;
   endtask

   // Directly after a send with both units empty and ready_in=1.
   task automatic lat_check(input string tag, input logic [31:0] addr, input logic mis_exp_a,
                            input logic mis_exp_b);
      int n;
      n = 1;
      @(negedge clk);
      chk({tag, "_b_valid"}, 64'(vo_b), 64'd1);
      chk({tag, "_b_addr_const"}, 64'(io_b), 64'(addr));
      chk({tag, "_b_mis_const"}, 64'(mis_b), 64'(mis_exp_b));
      while (!vo_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_a_latency"}, 64'(n), 64'd3);
      chk({tag, "_a_addr_const"}, 64'(io_a), 64'(addr));
      chk({tag, "_a_mis_const"}, 64'(mis_a), 64'(mis_exp_a));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      ready_in = 1'b1;
      while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_drain_a"}, 64'(qa.size()), 64'd0);
      chk({tag, "_drain_b"}, 64'(qb.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int na0;
      bit done;

      // Reset state
      @(posedge clk);
      #2;
      chk("rst_vo_a", 64'(vo_a), 64'd0);
      chk("rst_io_a", 64'(io_a), 64'd0);
      chk("rst_mis_a", 64'(mis_a), 64'd0);
      chk("rst_mo_a", 64'(mo_a), 64'd0);
      chk("rst_vo_b", 64'(vo_b), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ro_a", 64'(ro_a), 64'd1);
      chk("rst_ro_b", 64'(ro_b), 64'd1);
      @(posedge clk);
      #1;

      // Directed modes
      send(2'b00, 32'h0000_1000, 32'h0, 32'hFFFF_FFFC);
      lat_check("m00", 32'h0000_0FFC, 1'b0, 1'b0);
      send(2'b10, 32'h0, 32'h0000_2003, 32'h0);
      lat_check("m10", 32'h0000_2002, 1'b1, 1'b0);
      send(2'b01, 32'h0, 32'hFFFF_FFFF, 32'h2);
      lat_check("m01", 32'h0000_0001, 1'b0, 1'b0);
      send(2'b11, 32'h0000_0100, 32'h1234_5677, 32'h7654_3211);
      lat_check("m11", 32'h0000_0104, 1'b0, 1'b0);
      send(2'b00, 32'h0000_2000, 32'h0, 32'h0000_0006);
      lat_check("m00_mis", 32'h0000_2006, 1'b1, 1'b0);
      drain("dir");

      // Back-to-back with backpressure from cycle 4 to 8
      na0 = na;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(2'(i), 32'h4000 + 32'(i * 16), 32'h8000_0000 + 32'(i), 32'(i * 3));
         end
         begin
            repeat (3) @(posedge clk);
            #1 ready_in = 1'b0;
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("bp_full_ready_out", 64'(ro_a), 64'd0);
            @(posedge clk);
            #1 ready_in = 1'b1;
         end
      join
      drain("bp");
      chk("bp_count", 64'(na - na0), 64'd6);

      // Flush with two in flight and an offered input
      ready_in = 1'b0;
      send(2'b01, 32'h0, 32'h0000_5000, 32'h10);
      send(2'b01, 32'h0, 32'h0000_6000, 32'h20);
      @(posedge clk);
      #1;
      mode_in = 2'b00; pc_in = 32'hDEAD_0000; imm_in = 32'h4;
      valid_in = 1'b1;
      flush_in = 1'b1;
      @(negedge clk);
      chk("fl_ro_a", 64'(ro_a), 64'd1);
      chk("fl_ro_b", 64'(ro_b), 64'd1);
      @(posedge clk);
      #1 flush_in = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(negedge clk);
      chk("fl_vo_a", 64'(vo_a), 64'd0);
      chk("fl_vo_b", 64'(vo_b), 64'd0);
      @(posedge clk);
      #1;
      send(2'b10, 32'h0, 32'h0000_7001, 32'h0000_0004);
      lat_check("post_flush", 32'h0000_7004, 1'b0, 1'b0);
      drain("fl");

      // Random traffic with random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 30; i++)
               send(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 ready_in = 1'($urandom_range(0, 1));
            end
         end
      join
      drain("rnd");

      // Asynchronous reset in the middle of a stall
      ready_in = 1'b0;
      send(2'b10, 32'h0, 32'h0000_3006, 32'h0);
      send(2'b01, 32'h0, 32'h0000_0040, 32'h4);
      repeat (2) @(posedge clk);
      #2;
      chk("rs_pre_vo_a", 64'(vo_a), 64'd1);
      rst = 1'b1;
      #1;
      chk("rs_vo_a", 64'(vo_a), 64'd0);
      chk("rs_io_a", 64'(io_a), 64'd0);
      chk("rs_mis_a", 64'(mis_a), 64'd0);
      chk("rs_mo_a", 64'(mo_a), 64'd0);
      chk("rs_vo_b", 64'(vo_b), 64'd0);
      chk("rs_io_b", 64'(io_b), 64'd0);
      chk("rs_mo_b", 64'(mo_b), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      ready_in = 1'b1;
      @(negedge clk);
      chk("rs_ro_a", 64'(ro_a), 64'd1);
      chk("rs_ro_b", 64'(ro_b), 64'd1);
      chk("rs_post_vo_a", 64'(vo_a), 64'd0);
      @(posedge clk);
      #1;
      send(2'b11, 32'h0000_0FFC, 32'h0, 32'h0);
      lat_check("post_rst", 32'h0000_1000, 1'b0, 1'b0);
      drain("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
